// File: rtl/axi_lite_wr_master.sv
// Single-outstanding AXI4-Lite write master: takes one-cycle register write
// requests and runs the AW/W/B handshakes, flagging slave errors, overruns and timeouts.
module axi_lite_wr_master #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lite_valid,
   input  logic [ADDR_W-1:0]   lite_awaddr,
   input  logic [DATA_W-1:0]   lite_wdata,
   output logic                lite_end,
   output logic [1:0]          lite_resp,
   output logic                lite_busy,
   output logic                err_slv,
   output logic                err_ovr,
   output logic                err_tmo,
   input  logic                err_clr,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic [2:0]          m_axi_awprot,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   output logic [1:0]          dbg_state
);

   // Handshake rule on every channel: a beat transfers on a rising edge where
   // VALID and READY are both 1; VALID never drops and its payload never
   // changes until that edge, and READY may be driven independently of VALID.

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ADDR_DATA = 2'd1,
      S_RESP      = 2'd2
   } state_t;

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state, state_nxt;
   logic             aw_done, w_done;
   logic             aw_hs, w_hs, b_hs;
   logic             tmo_hit;
   logic [CNT_W-1:0] tmo_cnt;

   assign aw_hs        = m_axi_awvalid & m_axi_awready;
   assign w_hs         = m_axi_wvalid & m_axi_wready;
   assign b_hs         = m_axi_bvalid & m_axi_bready;
   assign m_axi_bready = (state == S_RESP);
   assign m_axi_awprot = 3'b000;
   assign m_axi_wstrb  = '1;
   assign lite_busy    = (state != S_IDLE);
   assign dbg_state    = state;
   // The increment happening this cycle is the one that reaches TIMEOUT_CYC.
   assign tmo_hit      = (state != S_IDLE) && (tmo_cnt >= TMO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (lite_valid) state_nxt = S_ADDR_DATA;
         S_ADDR_DATA: if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = S_RESP;
         S_RESP:      if (b_hs) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_axi_awaddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         lite_end      <= 1'b0;
         lite_resp     <= 2'b00;
      end else begin
         lite_end <= 1'b0;
         case (state)
            S_IDLE: begin
               aw_done <= 1'b0;
               w_done  <= 1'b0;
               if (lite_valid) begin
                  m_axi_awaddr  <= lite_awaddr;
                  m_axi_wdata   <= lite_wdata;
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
               end
            end
            S_ADDR_DATA: begin
               if (aw_hs) begin
                  m_axi_awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  m_axi_wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
            end
            S_RESP: begin
               if (b_hs) begin
                  lite_resp <= m_axi_bresp;
                  lite_end  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    tmo_cnt <= '0;
      else if (state == S_IDLE)   tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
   end

   // A new error event in the same cycle as err_clr wins over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_slv <= 1'b0;
         err_ovr <= 1'b0;
         err_tmo <= 1'b0;
      end else begin
         err_slv <= (err_slv & ~err_clr) | (b_hs & (m_axi_bresp != 2'b00));
         err_ovr <= (err_ovr & ~err_clr) | (lite_valid & (state != S_IDLE));
         err_tmo <= (err_tmo & ~err_clr) | tmo_hit;
      end
   end

endmodule

// File: tb/tb_axi_lite_wr_master.sv
// Directed bench for axi_lite_wr_master: the initial block plays upstream and
// slave, a negedge monitor scores AW/W payloads and completion responses.
module tb_axi_lite_wr_master;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int TMO    = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                lite_valid;
   logic [ADDR_W-1:0]   lite_awaddr;
   logic [DATA_W-1:0]   lite_wdata;
   logic                lite_end;
   logic [1:0]          lite_resp;
   logic                lite_busy;
   logic                err_slv, err_ovr, err_tmo;
   logic                err_clr;
   logic [ADDR_W-1:0]   m_axi_awaddr;
   logic [2:0]          m_axi_awprot;
   logic                m_axi_awvalid, m_axi_awready;
   logic [DATA_W-1:0]   m_axi_wdata;
   logic [DATA_W/8-1:0] m_axi_wstrb;
   logic                m_axi_wvalid, m_axi_wready;
   logic [1:0]          m_axi_bresp;
   logic                m_axi_bvalid, m_axi_bready;
   logic [1:0]          dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int aw_cnt  = 0;
   int end_cnt = 0;

   logic [ADDR_W-1:0] exp_aw_q[$];
   logic [DATA_W-1:0] exp_w_q[$];
   logic [1:0]        exp_resp_q[$];

   axi_lite_wr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .lite_valid(lite_valid), .lite_awaddr(lite_awaddr), .lite_wdata(lite_wdata),
      .lite_end(lite_end), .lite_resp(lite_resp), .lite_busy(lite_busy),
      .err_slv(err_slv), .err_ovr(err_ovr), .err_tmo(err_tmo), .err_clr(err_clr),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver: one-cycle request, expectations queued for the monitor
   task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input logic [1:0] resp);
      lite_valid  = 1'b1;
      lite_awaddr = a;
      lite_wdata  = d;
      exp_aw_q.push_back(a);
      exp_w_q.push_back(d);
      exp_resp_q.push_back(resp);
      tick();
      lite_valid = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n = 0;
      while (!lite_end && n < budget) begin
         tick();
         n++;
      end
      check(tag, lite_end, 1'b1);
   endtask

   task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br);
      m_axi_awready = awr;
      m_axi_wready  = wr;
      m_axi_bvalid  = bv;
      m_axi_bresp   = br;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (m_axi_awvalid && m_axi_awready) begin
            aw_cnt++;
            if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
            else check("aw_addr", m_axi_awaddr, exp_aw_q.pop_front());
         end
         if (m_axi_wvalid && m_axi_wready) begin
            if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
            else check("w_data", m_axi_wdata, exp_w_q.pop_front());
            check("w_strb", m_axi_wstrb, 4'hf);
         end
         if (lite_end) begin
            end_cnt++;
            if (exp_resp_q.size() == 0) check("end_unexpected", 1, 0);
            else check("lite_resp", lite_resp, exp_resp_q.pop_front());
         end
      end
   end

   initial begin
      int aw0, end0;
      rst         = 1'b1;
      lite_valid  = 1'b0;
      lite_awaddr = '0;
      lite_wdata  = '0;
      err_clr     = 1'b0;
      slave(1'b0, 1'b0, 1'b0, 2'b00);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state
      check("rst_awvalid", m_axi_awvalid, 1'b0);
      check("rst_wvalid", m_axi_wvalid, 1'b0);
      check("rst_bready", m_axi_bready, 1'b0);
      check("rst_busy", lite_busy, 1'b0);
      check("rst_end", lite_end, 1'b0);
      check("rst_errs", {err_slv, err_ovr, err_tmo}, 3'b000);
      check("rst_resp", lite_resp, 2'b00);
      check("rst_awaddr", m_axi_awaddr, 0);
      check("rst_wdata", m_axi_wdata, 0);
      check("rst_awprot", m_axi_awprot, 3'b000);

      // zero-wait slave, plus back-to-back request on the lite_end cycle
      slave(1'b1, 1'b1, 1'b1, 2'b00);
      send(10'h030, 32'h0001_1003, 2'b00);
      check("t1_c1_awvalid", m_axi_awvalid, 1'b1);
      check("t1_c1_wvalid", m_axi_wvalid, 1'b1);
      check("t1_c1_awaddr", m_axi_awaddr, 10'h030);
      check("t1_c1_wdata", m_axi_wdata, 32'h0001_1003);
      check("t1_c1_busy", lite_busy, 1'b1);
      tick();
      check("t1_c2_bready", m_axi_bready, 1'b1);
      check("t1_c2_awvalid", m_axi_awvalid, 1'b0);
      check("t1_c2_end", lite_end, 1'b0);
      tick();
      check("t1_c3_end", lite_end, 1'b1);
      check("t1_c3_busy", lite_busy, 1'b0);
      check("t1_c3_errs", {err_slv, err_ovr, err_tmo}, 3'b000);
      send(10'h034, 32'hcafe_0001, 2'b00);
      check("t1_b2b_awvalid", m_axi_awvalid, 1'b1);
      check("t1_b2b_end_width", lite_end, 1'b0);
      check("t1_b2b_ovr", err_ovr, 1'b0);
      wait_end("t1_b2b_end", 8);
      tick();
      check("t1_end_width", lite_end, 1'b0);

      // AWREADY delayed 5 cycles, WREADY immediate
      slave(1'b0, 1'b1, 1'b0, 2'b00);
      send(10'h044, 32'h1234_5678, 2'b00);
      check("t2_c1_wvalid", m_axi_wvalid, 1'b1);
      tick();
      check("t2_c2_wvalid", m_axi_wvalid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("t2_awvalid_hold", m_axi_awvalid, 1'b1);
         check("t2_awaddr_hold", m_axi_awaddr, 10'h044);
         check("t2_bready_low", m_axi_bready, 1'b0);
         tick();
      end
      m_axi_awready = 1'b1;
      tick();
      m_axi_awready = 1'b0;
      check("t2_awvalid_drop", m_axi_awvalid, 1'b0);
      check("t2_bready_up", m_axi_bready, 1'b1);
      m_axi_bvalid = 1'b1;
      tick();
      check("t2_end", lite_end, 1'b1);
      m_axi_bvalid = 1'b0;
      tick();

      // BVALID early, before WREADY
      slave(1'b1, 1'b0, 1'b1, 2'b00);
      end0 = end_cnt;
      send(10'h050, 32'h0bad_f00d, 2'b00);
      tick();
      check("t3_c2_wvalid", m_axi_wvalid, 1'b1);
      check("t3_c2_bready", m_axi_bready, 1'b0);
      tick();
      check("t3_c3_bready", m_axi_bready, 1'b0);
      check("t3_c3_noend", end_cnt - end0, 0);
      m_axi_wready = 1'b1;
      tick();
      check("t3_c4_bready", m_axi_bready, 1'b1);
      tick();
      check("t3_end", lite_end, 1'b1);
      slave(1'b1, 1'b1, 1'b1, 2'b10);

      // SLVERR response, sticky until err_clr
      tick();
      send(10'h010, 32'h0000_00ff, 2'b10);
      wait_end("t4_end", 8);
      check("t4_resp", lite_resp, 2'b10);
      check("t4_slv", err_slv, 1'b1);
      tick();
      check("t4_resp_held", lite_resp, 2'b10);
      check("t4_slv_sticky", err_slv, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t4_slv_clr", err_slv, 1'b0);

      // overrun while stalled; err_clr in the same cycle loses to the set
      slave(1'b0, 1'b0, 1'b0, 2'b00);
      aw0  = aw_cnt;
      end0 = end_cnt;
      send(10'h060, 32'h6060_6060, 2'b00);
      lite_valid  = 1'b1;
      lite_awaddr = 10'h3ff;
      lite_wdata  = 32'hdead_beef;
      err_clr     = 1'b1;
      tick();
      lite_valid = 1'b0;
      err_clr    = 1'b0;
      check("t5_ovr", err_ovr, 1'b1);
      check("t5_awaddr_kept", m_axi_awaddr, 10'h060);
      slave(1'b1, 1'b1, 1'b0, 2'b00);
      tick();
      slave(1'b0, 1'b0, 1'b1, 2'b00);
      wait_end("t5_end", 8);
      m_axi_bvalid = 1'b0;
      repeat (3) tick();
      check("t5_one_aw", aw_cnt - aw0, 1);
      check("t5_one_end", end_cnt - end0, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("t5_ovr_clr", err_ovr, 1'b0);

      // timeout with AWREADY low for 20 busy cycles
      slave(1'b0, 1'b1, 1'b0, 2'b00);
      send(10'h070, 32'h7070_7070, 2'b00);
      repeat (14) tick();
      check("t6_tmo_c15", err_tmo, 1'b0);
      repeat (2) tick();
      check("t6_tmo_c17", err_tmo, 1'b1);
      check("t6_awvalid_c17", m_axi_awvalid, 1'b1);
      repeat (3) tick();
      check("t6_awvalid_c20", m_axi_awvalid, 1'b1);
      check("t6_busy_c20", lite_busy, 1'b1);
      m_axi_awready = 1'b1;
      tick();
      slave(1'b0, 1'b0, 1'b1, 2'b00);
      wait_end("t6_end", 8);
      m_axi_bvalid = 1'b0;
      tick();
      check("t6_tmo_sticky", err_tmo, 1'b1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tick();
      check("t6_errs_clr", {err_slv, err_ovr, err_tmo}, 3'b000);

      // reset while in RESP, then a fresh request
      slave(1'b1, 1'b1, 1'b0, 2'b00);
      end0 = end_cnt;
      send(10'h080, 32'h8080_8080, 2'b01);
      tick();
      check("t7_bready_resp", m_axi_bready, 1'b1);
      rst = 1'b1;
      #1;
      check("t7_rst_bready", m_axi_bready, 1'b0);
      check("t7_rst_busy", lite_busy, 1'b0);
      check("t7_rst_end", lite_end, 1'b0);
      check("t7_rst_awvalid", m_axi_awvalid, 1'b0);
      exp_resp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      check("t7_no_end", end_cnt - end0, 0);
      slave(1'b1, 1'b1, 1'b1, 2'b00);
      send(10'h090, 32'h9090_9090, 2'b00);
      wait_end("t7_fresh_end", 8);
      check("t7_fresh_resp", lite_resp, 2'b00);
      slave(1'b0, 1'b0, 1'b0, 2'b00);
      repeat (2) tick();

      check("queues_empty", exp_aw_q.size() + exp_w_q.size() + exp_resp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_wr_master.md
# axi_lite_wr_master

Single-outstanding AXI4-Lite write master that sits directly downstream of the S2MM/MM2S register-programming controllers. It accepts one-cycle `lite_valid` requests carrying `lite_awaddr`/`lite_wdata` and performs the AW/W/B handshakes to the DMA register port. It returns a one-cycle `lite_end` pulse and the write response when each write completes. Protocol errors and upstream overruns are flagged for debug.

## Interface
- `ADDR_W`, 10: request and AXI address width.
- `DATA_W`, 32: data width; `WSTRB` width is `DATA_W/8`.
- `TIMEOUT_CYC`, 1024: busy-cycle count that sets the sticky timeout flag.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `lite_valid` input 1: one-cycle request strobe; address and data are valid in the same cycle.
- `lite_awaddr` input ADDR_W: register address.
- `lite_wdata` input DATA_W: register data.
- `lite_end` output 1: one-cycle completion pulse.
- `lite_resp` output 2: BRESP of the last completed write; valid while `lite_end`=1 and held after.
- `lite_busy` output 1: a transaction is in flight.
- `err_slv` output 1: sticky; set when any BRESP≠2'b00.
- `err_ovr` output 1: sticky; set when `lite_valid` arrives while busy.
- `err_tmo` output 1: sticky; set when a transaction has been busy for TIMEOUT_CYC cycles.
- `err_clr` input 1: synchronous clear of all three sticky flags.
- `m_axi_awaddr` output ADDR_W, `m_axi_awprot` output 3 (constant 3'b000), `m_axi_awvalid` output 1, `m_axi_awready` input 1: AW channel.
- `m_axi_wdata` output DATA_W, `m_axi_wstrb` output DATA_W/8 (constant all-ones), `m_axi_wvalid` output 1, `m_axi_wready` input 1: W channel.
- `m_axi_bresp` input 2, `m_axi_bvalid` input 1, `m_axi_bready` output 1: B channel.

## Operation
- States: IDLE, ADDR_DATA, RESP.
- IDLE:
  - `lite_valid`=1 registers `lite_awaddr`→`m_axi_awaddr` and `lite_wdata`→`m_axi_wdata`.
  - Sets `m_axi_awvalid` and `m_axi_wvalid` to 1, then goes to ADDR_DATA.
- ADDR_DATA:
  - AW and W are tracked independently by `aw_done`/`w_done` flags.
  - `m_axi_awvalid` drops the cycle after `awvalid & awready`; `m_axi_wvalid` drops the cycle after `wvalid & wready`.
  - Either order is legal, as is both in the same cycle.
  - A VALID never drops before its READY.
  - Address and data are stable while the corresponding VALID is high.
  - When both handshakes are complete, go to RESP.
- RESP:
  - `m_axi_bready`=1.
  - On `bvalid & bready`: capture `bresp` into `lite_resp`, set `err_slv` if `bresp`≠0, pulse `lite_end`, and return to IDLE.
- `m_axi_bready` is 0 outside RESP. A BVALID seen before both AW and W handshakes complete is not accepted.
- `lite_valid` while not in IDLE: the request is dropped, `err_ovr` is set, and the in-flight transaction is unaffected.
- Timeout counter:
  - Cleared in IDLE; increments every non-IDLE cycle and saturates at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC sets `err_tmo`.
  - The transaction is never aborted; AXI rules take precedence.
- `err_clr` and a new error event in the same cycle: the set wins.
- `lite_busy` = (state≠IDLE).

## Timing
- Reset values: all VALIDs, `m_axi_bready`, `lite_end`, `lite_busy` and the `err_*` flags are 0; `lite_resp`=0; addresses and data are 0; state is IDLE.
- Reset asserted mid-transaction clears the outputs immediately (asynchronously). No completion pulse follows.
- Request latency: `lite_valid` at cycle 0 gives `m_axi_awvalid`/`m_axi_wvalid`=1 at cycle 1.
- With zero-wait slave (READYs and BVALID always high):
  - AW and W handshake at cycle 1.
  - `m_axi_bready`=1 at cycle 2; B handshake at cycle 2.
  - `lite_end`=1 at cycle 3 with state IDLE.
  - Minimum request-to-`lite_end` latency is 3 cycles.
- `lite_end` is exactly one cycle wide. Upstream FSMs advance on a combinational `lite_end`, so a wider pulse is a bug.
- A `lite_valid` in the same cycle as `lite_end` is accepted, since state is already IDLE.

## Test plan
- Zero-wait slave, request addr 0x30 / data 0x0001_1003:
  - `m_axi_awaddr`=0x30 and `m_axi_wdata`=0x0001_1003 with VALIDs at cycle 1.
  - `lite_end` pulse at cycle 3 with `lite_resp`=0 and no error flags.
- AWREADY delayed 5 cycles, WREADY immediate:
  - `wvalid` drops after cycle 1; `awvalid` is held through the 5-cycle stall.
  - `bready` rises only after the AW handshake; `lite_end` follows one cycle after BVALID.
- Slave asserts BVALID early, before WREADY: the B handshake is not taken until W completes, then is taken normally.
- BRESP=2'b10 (SLVERR): `lite_resp`=2'b10 with `lite_end`, and `err_slv`=1 until `err_clr`.
- Second `lite_valid` 1 cycle after the first, with the slave stalling:
  - `err_ovr`=1; exactly one AW/W transaction and one `lite_end` occur.
  - Then TIMEOUT_CYC=16 with AWREADY held low for 20 cycles: `err_tmo`=1 at busy cycle 16, and `awvalid` is still 1.
- `rst` pulsed while in RESP: `bready`, `lite_busy` and `lite_end` are 0 immediately. A fresh request after reset completes normally.
